mem_port_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between the multi-cycle CPU and a boot/debug loader. The CPU has fixed priority for single accesses; the loader issues atomic incrementing word bursts, which the arbiter sequences with its own address and beat counters. `cpu_stall` tells the CPU controller to hold its state, PC, IR and MDR updates while it is denied the memory. Memory reads are combinational; writes commit on the rising clock edge.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_burst_ctr.sv | 38 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/loader memory port arbiter.
// Optional feature macro: MEM_ARB_YIELD_EN (periodic yield to the CPU during long bursts).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LDR   = 2'd1,
        S_YIELD = 2'd2
    } arb_state_e;

    localparam int unsigned BEAT_STRIDE = 4;
    localparam int unsigned MAX_RUN_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, loader and memory-side signals of the shared memory port.
// slave: arbiter view; master: the environment (CPU, loader, memory) view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);

    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [LEN_W-1:0]  ldr_len;
    logic              ldr_ack;
    logic              ldr_beat;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_len, ldr_wdata,
        output ldr_ack, ldr_beat, ldr_rdata, ldr_done,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_len, ldr_wdata,
        input  ldr_ack, ldr_beat, ldr_rdata, ldr_done,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_burst_ctr.sv
// Loader burst address and remaining-beat counter.
module mem_arb_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              last
);

    logic [LEN_W-1:0] beats_left;

    // Load on burst accept; advance one word and count down on each beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_addr <= '0;
            beats_left <= '0;
        end else if (load) begin
            burst_addr <= load_addr;
            beats_left <= load_len;
        end else if (step) begin
            burst_addr <= burst_addr + ADDR_W'(BEAT_STRIDE);
            if (!last) begin
                beats_left <= beats_left - LEN_W'(1);
            end
        end
    end

    assign last = (beats_left == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified memory: CPU single accesses have
// priority in idle, the loader gets atomic incrementing word bursts.
// Optional feature macro: MEM_ARB_YIELD_EN (hand the port to a waiting CPU
// for one cycle after every MAX_RUN consecutive loader beats).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 8
`ifdef MEM_ARB_YIELD_EN
    ,
    parameter int unsigned MAX_RUN = MAX_RUN_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              we_q;
    logic              cpu_req_c;
    logic              load_c;
    logic              step_c;
    logic              last;
    logic [ADDR_W-1:0] burst_addr;

    assign cpu_req_c     = bus.cpu_rd | bus.cpu_wr;
    assign bus.cpu_rdata = DATA_W'(bus.mem_rdata);
    assign bus.ldr_rdata = DATA_W'(bus.mem_rdata);

    mem_arb_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .load_addr  (bus.ldr_addr),
        .load_len   (bus.ldr_len),
        .step       (step_c),
        .burst_addr (burst_addr),
        .last       (last)
    );

`ifdef MEM_ARB_YIELD_EN
    localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             run_full_c;

    // True when the current beat completes a run of MAX_RUN beats.
    assign run_full_c = (32'(run_cnt) + 32'd1) >= MAX_RUN;

    // Consecutive-beat counter; saturates while the CPU is not asking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if ((state_q != S_LDR) || (state_d == S_YIELD)) begin
            run_cnt <= '0;
        end else if (32'(run_cnt) < MAX_RUN) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end
`endif

    // State register and latched burst direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_c) begin
                we_q <= bus.ldr_we;
            end
        end
    end

    // Next state and port steering; CPU mirror is the default ownership.
    always_comb begin
        state_d       = state_q;
        load_c        = 1'b0;
        step_c        = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_wr    = bus.cpu_wr;
        bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
        bus.cpu_stall = 1'b0;
        bus.ldr_ack   = 1'b0;
        bus.ldr_beat  = 1'b0;
        bus.ldr_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.ldr_req && !cpu_req_c) begin
                    load_c      = 1'b1;
                    bus.ldr_ack = 1'b1;
                    state_d     = S_LDR;
                end
            end
            S_LDR: begin
                step_c        = 1'b1;
                bus.ldr_beat  = 1'b1;
                bus.mem_addr  = burst_addr;
                bus.mem_wdata = bus.ldr_wdata;
                bus.mem_wr    = we_q;
                bus.mem_rd    = ~we_q;
                bus.cpu_stall = cpu_req_c;
                if (last) begin
                    bus.ldr_done = 1'b1;
                    state_d      = S_IDLE;
                end
`ifdef MEM_ARB_YIELD_EN
                else if (cpu_req_c && run_full_c) begin
                    state_d = S_YIELD;
                end
`endif
            end
            S_YIELD: begin
`ifdef MEM_ARB_YIELD_EN
                state_d = S_LDR;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Memory model: read data = address ^ 32'h5A5A_0000 (combinational).
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LEN_W   (8)
`ifdef MEM_ARB_YIELD_EN
        ,
        .MAX_RUN (4)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_addr ^ 32'h5A5A_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ldr_req   = 1'b0;
        bus.ldr_we    = 1'b0;
        bus.ldr_addr  = '0;
        bus.ldr_len   = '0;
        bus.ldr_wdata = '0;

        // Reset state
        #2;
        chk("rst_mem_rd",  32'(bus.mem_rd),    32'd0);
        chk("rst_mem_wr",  32'(bus.mem_wr),    32'd0);
        chk("rst_stall",   32'(bus.cpu_stall), 32'd0);
        chk("rst_ack",     32'(bus.ldr_ack),   32'd0);
        chk("rst_done",    32'(bus.ldr_done),  32'd0);
        chk("rst_beat",    32'(bus.ldr_beat),  32'd0);
        tick();
        reset = 1'b1;

        // CPU-only traffic
        tick();
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 32'h40;
        #1;
        chk("cpu_addr",  bus.mem_addr,          32'h40);
        chk("cpu_rd",    32'(bus.mem_rd),       32'd1);
        chk("cpu_wr",    32'(bus.mem_wr),       32'd0);
        chk("cpu_stall", 32'(bus.cpu_stall),    32'd0);
        chk("cpu_rdata", bus.cpu_rdata,         32'h5A5A_0040);
        tick();
        bus.cpu_wr    = 1'b1;
        bus.cpu_wdata = 32'hCAFE_0001;
        #1;
        chk("both_wr",    32'(bus.mem_wr), 32'd1);
        chk("both_rd",    32'(bus.mem_rd), 32'd0);
        chk("both_wdata", bus.mem_wdata,   32'hCAFE_0001);
        tick();
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;

        // Write burst 0x100, 4 beats; CPU asks from beat 1 on
        tick();
        bus.ldr_req  = 1'b1;
        bus.ldr_we   = 1'b1;
        bus.ldr_addr = 32'h100;
        bus.ldr_len  = 8'd3;
        #1;
        chk("wr_ack",       32'(bus.ldr_ack),  32'd1);
        chk("wr_ack_nobeat", 32'(bus.ldr_beat), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.ldr_req   = 1'b0;
            bus.ldr_wdata = 32'hD000_0000 + 32'(i);
            if (i >= 1) begin
                bus.cpu_rd   = 1'b1;
                bus.cpu_addr = 32'h80;
            end
            #1;
            chk($sformatf("wr_beat%0d", i),  32'(bus.ldr_beat),  32'd1);
            chk($sformatf("wr_addr%0d", i),  bus.mem_addr,       32'h100 + 32'(4 * i));
            chk($sformatf("wr_wr%0d", i),    32'(bus.mem_wr),    32'd1);
            chk($sformatf("wr_rd%0d", i),    32'(bus.mem_rd),    32'd0);
            chk($sformatf("wr_data%0d", i),  bus.mem_wdata,      32'hD000_0000 + 32'(i));
            chk($sformatf("wr_done%0d", i),  32'(bus.ldr_done),  (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("wr_stall%0d", i), 32'(bus.cpu_stall), (i >= 1) ? 32'd1 : 32'd0);
        end
        tick();
        #1;
        chk("post_wr_beat",  32'(bus.ldr_beat),  32'd0);
        chk("post_wr_done",  32'(bus.ldr_done),  32'd0);
        chk("post_wr_stall", 32'(bus.cpu_stall), 32'd0);
        chk("post_wr_addr",  bus.mem_addr,       32'h80);
        chk("post_wr_rd",    32'(bus.mem_rd),    32'd1);

        // Contention: CPU wins, then single-beat read burst
        tick();
        bus.cpu_addr = 32'h44;
        bus.ldr_req  = 1'b1;
        bus.ldr_we   = 1'b0;
        bus.ldr_addr = 32'h200;
        bus.ldr_len  = 8'd0;
        #1;
        chk("cont_ack0",   32'(bus.ldr_ack),   32'd0);
        chk("cont_stall0", 32'(bus.cpu_stall), 32'd0);
        chk("cont_addr0",  bus.mem_addr,       32'h44);
        tick();
        #1;
        chk("cont_ack1", 32'(bus.ldr_ack), 32'd0);
        tick();
        bus.cpu_rd = 1'b0;
        #1;
        chk("cont_ack2", 32'(bus.ldr_ack), 32'd1);
        tick();
        bus.ldr_req = 1'b0;
        #1;
        chk("rd1_beat",  32'(bus.ldr_beat), 32'd1);
        chk("rd1_done",  32'(bus.ldr_done), 32'd1);
        chk("rd1_rd",    32'(bus.mem_rd),   32'd1);
        chk("rd1_addr",  bus.mem_addr,      32'h200);
        chk("rd1_rdata", bus.ldr_rdata,     32'h5A5A_0200);
        tick();
        #1;
        chk("rd1_idle_beat", 32'(bus.ldr_beat), 32'd0);
        chk("rd1_idle_done", 32'(bus.ldr_done), 32'd0);

        // Address wrap-around
        tick();
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 32'hFFFF_FFFC;
        bus.ldr_len  = 8'd1;
        #1;
        chk("wrap_ack", 32'(bus.ldr_ack), 32'd1);
        tick();
        bus.ldr_req = 1'b0;
        #1;
        chk("wrap_addr0", bus.mem_addr,      32'hFFFF_FFFC);
        chk("wrap_done0", 32'(bus.ldr_done), 32'd0);
        tick();
        #1;
        chk("wrap_addr1",  bus.mem_addr,      32'h0);
        chk("wrap_done1",  32'(bus.ldr_done), 32'd1);
        chk("wrap_rdata1", bus.ldr_rdata,     32'h5A5A_0000);

        // Reset during beat 2 of an 8-beat write burst
        tick();
        tick();
        bus.ldr_req  = 1'b1;
        bus.ldr_we   = 1'b1;
        bus.ldr_addr = 32'h300;
        bus.ldr_len  = 8'd7;
        #1;
        chk("rb_ack", 32'(bus.ldr_ack), 32'd1);
        tick();
        bus.ldr_req = 1'b0;
        #1;
        chk("rb_addr0", bus.mem_addr, 32'h300);
        tick();
        tick();
        #1;
        chk("rb_addr2", bus.mem_addr,      32'h308);
        chk("rb_beat2", 32'(bus.ldr_beat), 32'd1);
        reset = 1'b0;
        #1;
        chk("rb_rst_beat",  32'(bus.ldr_beat),  32'd0);
        chk("rb_rst_done",  32'(bus.ldr_done),  32'd0);
        chk("rb_rst_wr",    32'(bus.mem_wr),    32'd0);
        chk("rb_rst_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("rb_rel_beat", 32'(bus.ldr_beat), 32'd0);
        chk("rb_rel_wr",   32'(bus.mem_wr),   32'd0);
        tick();
        #1;
        chk("rb_idle_beat", 32'(bus.ldr_beat), 32'd0);
        chk("rb_idle_done", 32'(bus.ldr_done), 32'd0);

`ifdef MEM_ARB_YIELD_EN
        // Yield: MAX_RUN=4, 10 beats, CPU requesting throughout the burst
        tick();
        bus.ldr_req  = 1'b1;
        bus.ldr_we   = 1'b1;
        bus.ldr_addr = 32'h400;
        bus.ldr_len  = 8'd9;
        #1;
        chk("y_ack", 32'(bus.ldr_ack), 32'd1);
        begin
            int b;
            logic y;
            b = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                bus.ldr_req  = 1'b0;
                bus.cpu_rd   = 1'b1;
                bus.cpu_addr = 32'h84;
                #1;
                y = (c == 4) || (c == 9);
                chk($sformatf("y_beat%0d", c),  32'(bus.ldr_beat),  y ? 32'd0 : 32'd1);
                chk($sformatf("y_stall%0d", c), 32'(bus.cpu_stall), y ? 32'd0 : 32'd1);
                chk($sformatf("y_addr%0d", c),  bus.mem_addr,       y ? 32'h84 : 32'h400 + 32'(4 * b));
                chk($sformatf("y_done%0d", c),  32'(bus.ldr_done),  (c == 11) ? 32'd1 : 32'd0);
                if (!y) begin
                    b++;
                end
            end
        end
        tick();
        #1;
        chk("y_end_beat",  32'(bus.ldr_beat),  32'd0);
        chk("y_end_stall", 32'(bus.cpu_stall), 32'd0);
        bus.cpu_rd = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
